branch_resolve: RTL and testbench
=================================

Name: branch_resolve

Overview:
- Execute-stage consumer of the branch comparator outputs (less, equal).
- Decodes the branch funct3 and drives the comparator's signed/unsigned select.
- Resolves taken/not-taken for conditional branches and jumps, and checks the result against the fetch-stage prediction.
- On a mispredict, issues a registered PC redirect plus IF/ID and ID/EX flushes, with a wrong-path shadow window; also keeps saturating branch and mispredict counters.

Parameters:
- XLEN, 32, width of PC and target addresses
- CNT_W, 16, width of performance counters
- SHADOW_CYCLES, 1, cycles after a redirect during which new resolutions are ignored (range 0..7)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- ex_valid  input  1  EX stage holds a valid instruction
- ex_stall  input  1  EX stage held this cycle; no resolution accepted
- br_en  input  1  instruction is a conditional branch
- jmp_en  input  1  instruction is JAL/JALR (unconditionally taken)
- funct3  input  3  branch funct3 field
- less  input  1  comparator less result
- equal  input  1  comparator equal result
- pred_taken  input  1  fetch-stage prediction carried with the instruction
- ex_pc  input  XLEN  PC of the EX instruction
- target_addr  input  XLEN  computed branch/jump target
- cnt_clr  input  1  synchronous clear of both counters
- br_unsigned  output  1  signed/unsigned select to the comparator (combinational)
- redirect_valid  output  1  one-cycle pulse: fetch must load redirect_pc
- redirect_pc  output  XLEN  corrected fetch PC
- flush_ifid  output  1  kill IF/ID register contents
- flush_idex  output  1  kill ID/EX register contents
- taken_o  output  1  registered resolved direction of last accepted instruction
- illegal_o  output  1  one-cycle pulse: br_en with funct3 010/011
- br_cnt  output  CNT_W  accepted branches+jumps, saturating
- mispred_cnt  output  CNT_W  mispredicts, saturating

Behaviour:
- br_unsigned = funct3[1].
  - Purely combinational and valid whenever funct3 is driven, so the comparator settles in the same cycle.
- Condition decode:
  - 000 BEQ: equal
  - 001 BNE: !equal
  - 100 BLT: less
  - 101 BGE: !less
  - 110 BLTU: less
  - 111 BGEU: !less
  - 010/011: not taken; illegal_o pulses next cycle.
- Direction: actual = jmp_en | (br_en & cond). If br_en and jmp_en are both high, jmp_en wins and no illegal pulse is raised.
- accept = ex_valid & !ex_stall & (br_en|jmp_en) & state==IDLE.
  - Non-branch valid instructions are ignored: no counter change, taken_o holds.
- Mispredict = accept & (actual != pred_taken).
- Redirect target: target_addr if actual, else ex_pc + 4 (modulo 2^XLEN; wraps 0xFFFFFFFC -> 0x00000000).
- FSM states IDLE, REDIRECT, SHADOW.
  - IDLE -> REDIRECT on a mispredict accept.
  - REDIRECT lasts one cycle, with redirect_valid=flush_ifid=flush_idex=1 and redirect_pc registered.
  - REDIRECT -> SHADOW if SHADOW_CYCLES>0, else -> IDLE.
  - SHADOW counts SHADOW_CYCLES cycles, then -> IDLE.
  - ex_valid is ignored in REDIRECT and SHADOW (wrong-path instructions).
- Latency: a resolution in cycle N produces redirect/flush/taken_o/illegal_o in cycle N+1.
- Correct predictions update taken_o and counters only: no redirect, FSM stays IDLE.
- Counters:
  - br_cnt +1 per accept; mispred_cnt +1 per mispredict.
  - Both saturate at 2^CNT_W-1, with no wrap.
  - cnt_clr has priority over increment in the same cycle.
- ex_stall during IDLE blocks accept entirely; the same instruction is resolved when stall drops.
- Reset (async, rst_n low), applied any time including mid-REDIRECT/SHADOW:
  - state=IDLE, shadow counter=0
  - redirect_valid=0, redirect_pc=0, flush_ifid=0, flush_idex=0
  - taken_o=0, illegal_o=0, br_cnt=0, mispred_cnt=0
  - On deassertion, resolution resumes at the first accepted instruction.

Test Plan:
- BLT funct3=100, less=1, equal=0, pred_taken=0, ex_pc=0x100, target=0x180 -> br_unsigned=0; next cycle redirect_valid=1, redirect_pc=0x180, both flushes=1, taken_o=1, br_cnt=1, mispred_cnt=1.
- BGEU funct3=111, less=0, pred_taken=1, target=0x40 -> br_unsigned=1, no redirect, taken_o=1, br_cnt+1, mispred_cnt unchanged.
- BEQ, equal=0, pred_taken=1, ex_pc=0xFFFFFFFC -> redirect_pc=0x00000000 (wrap), not-taken fallthrough.
- Mispredict followed by a valid branch in the next 2 cycles with SHADOW_CYCLES=1 -> both following instructions ignored, counters unchanged, FSM back in IDLE in cycle N+3.
- br_en with funct3=010 -> illegal_o pulses for 1 cycle, taken_o=0; if pred_taken=1, redirect to ex_pc+4. Separately, br_en=jmp_en=1 with pred_taken=0 -> redirect to target_addr, illegal_o=0.
- br_cnt preloaded to 0xFFFF via repeated accepts (CNT_W=16) -> stays 0xFFFF; cnt_clr concurrent with accept -> 0. Also: rst_n low during REDIRECT -> all outputs 0 immediately (async).

Source files
------------

// File: rtl/branch_resolve.sv
// branch_resolve
//   Execute-stage branch resolution. Decodes the branch funct3, steers the
//   comparator signed/unsigned select, resolves the actual direction of
//   branches and jumps, and compares it with the fetch-stage prediction.
//   A mispredict produces a one-cycle registered redirect with IF/ID and
//   ID/EX flushes, followed by a wrong-path shadow window during which new
//   resolutions are ignored. Saturating counters track accepted control
//   transfers and mispredicts.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   ex_valid, ex_stall  EX holds a valid instruction / EX held this cycle
//   br_en, jmp_en       conditional branch / unconditional jump
//   funct3              branch condition field
//   less, equal         comparator results
//   pred_taken          fetch-stage prediction
//   ex_pc, target_addr  instruction PC and computed target
//   cnt_clr             synchronous clear of both counters
//   br_unsigned         comparator signed/unsigned select (combinational)
//   redirect_valid      one-cycle pulse, fetch loads redirect_pc
//   redirect_pc         corrected fetch PC
//   flush_ifid/idex     kill IF/ID and ID/EX contents
//   taken_o             resolved direction of the last accepted instruction
//   illegal_o           one-cycle pulse for branch funct3 010/011
//   br_cnt, mispred_cnt saturating performance counters
module branch_resolve #(
  parameter int XLEN          = 32,
  parameter int CNT_W         = 16,
  parameter int SHADOW_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             ex_stall,
  input  logic             br_en,
  input  logic             jmp_en,
  input  logic [2:0]       funct3,
  input  logic             less,
  input  logic             equal,
  input  logic             pred_taken,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  target_addr,
  input  logic             cnt_clr,
  output logic             br_unsigned,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             taken_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  typedef enum logic [1:0] {IDLE, REDIRECT, SHADOW} state_t;

  // The shadow counter is loaded with SHADOW_CYCLES-1 so that the SHADOW
  // state lasts exactly SHADOW_CYCLES cycles.
  localparam logic [2:0] SHADOW_INIT =
    (SHADOW_CYCLES > 0) ? 3'(SHADOW_CYCLES - 1) : 3'd0;

  state_t     state;
  logic [2:0] shadow_cnt;
  logic       cond;
  logic       actual;
  logic       accept;
  logic       mispredict;
  logic       illegal_f3;

  // funct3[1] distinguishes BLTU/BGEU from BLT/BGE; the comparator needs it
  // in the same cycle, so it is not registered.
  assign br_unsigned = funct3[1];

  // Branch condition decode from the comparator results.
  always_comb begin
    cond = 1'b0;
    case (funct3)
      3'b000:  cond = equal;
      3'b001:  cond = ~equal;
      3'b100:  cond = less;
      3'b101:  cond = ~less;
      3'b110:  cond = less;
      3'b111:  cond = ~less;
      default: cond = 1'b0;
    endcase
  end

  // A jump overrides the branch path, including the illegal-funct3 report.
  assign actual     = jmp_en | (br_en & cond);
  assign accept     = ex_valid & ~ex_stall & (br_en | jmp_en) & (state == IDLE);
  assign mispredict = accept & (actual != pred_taken);
  assign illegal_f3 = br_en & ~jmp_en & (funct3[2:1] == 2'b01);

  // Redirect FSM with registered outputs. Pulse outputs default low each
  // cycle and are raised only on the transition into REDIRECT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      shadow_cnt     <= 3'd0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush_ifid     <= 1'b0;
      flush_idex     <= 1'b0;
      taken_o        <= 1'b0;
      illegal_o      <= 1'b0;
    end else begin
      redirect_valid <= 1'b0;
      flush_ifid     <= 1'b0;
      flush_idex     <= 1'b0;
      illegal_o      <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            taken_o   <= actual;
            illegal_o <= illegal_f3;
            if (mispredict) begin
              state          <= REDIRECT;
              redirect_valid <= 1'b1;
              flush_ifid     <= 1'b1;
              flush_idex     <= 1'b1;
              redirect_pc    <= actual ? target_addr : (ex_pc + XLEN'(4));
            end
          end
        end
        REDIRECT: begin
          if (SHADOW_CYCLES > 0) begin
            state      <= SHADOW;
            shadow_cnt <= SHADOW_INIT;
          end else begin
            state <= IDLE;
          end
        end
        SHADOW: begin
          if (shadow_cnt == 3'd0) begin
            state <= IDLE;
          end else begin
            shadow_cnt <= shadow_cnt - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating performance counters; a clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt      <= '0;
      mispred_cnt <= '0;
    end else if (cnt_clr) begin
      br_cnt      <= '0;
      mispred_cnt <= '0;
    end else begin
      if (accept && (br_cnt != '1)) begin
        br_cnt <= br_cnt + CNT_W'(1);
      end
      if (mispredict && (mispred_cnt != '1)) begin
        mispred_cnt <= mispred_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve
//   Self-checking bench for branch_resolve. A behavioural model tracks the
//   expected outputs: a blocked-cycle countdown stands in for the
//   redirect/shadow window, counters are plain integers clipped at their
//   maximum. Directed steps cover the listed scenarios, then randomized
//   traffic, counter saturation, clear priority and asynchronous reset.
module tb_branch_resolve;

  localparam int XLEN    = 32;
  localparam int CNT_W   = 16;
  localparam int SHADOW  = 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             ex_valid;
  logic             ex_stall;
  logic             br_en;
  logic             jmp_en;
  logic [2:0]       funct3;
  logic             less;
  logic             equal;
  logic             pred_taken;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  target_addr;
  logic             cnt_clr;
  logic             br_unsigned;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             flush_ifid;
  logic             flush_idex;
  logic             taken_o;
  logic             illegal_o;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  int compared;
  int mismatched;

  // Reference model state
  int              m_blocked;
  logic            m_taken;
  logic            m_illegal;
  logic            m_redirect;
  logic [XLEN-1:0] m_pc;
  int              m_br;
  int              m_mp;

  branch_resolve #(.XLEN(XLEN), .CNT_W(CNT_W), .SHADOW_CYCLES(SHADOW)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_stall(ex_stall),
    .br_en(br_en), .jmp_en(jmp_en), .funct3(funct3), .less(less),
    .equal(equal), .pred_taken(pred_taken), .ex_pc(ex_pc),
    .target_addr(target_addr), .cnt_clr(cnt_clr), .br_unsigned(br_unsigned),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .taken_o(taken_o),
    .illegal_o(illegal_o), .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [XLEN-1:0] obs,
                     input logic [XLEN-1:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  task automatic modelReset();
    m_blocked  = 0;
    m_taken    = 1'b0;
    m_illegal  = 1'b0;
    m_redirect = 1'b0;
    m_pc       = '0;
    m_br       = 0;
    m_mp       = 0;
  endtask

  function automatic logic branchCond(input logic [2:0] f, input logic lt,
                                      input logic eq);
    case (f)
      3'd0:       return eq;
      3'd1:       return !eq;
      3'd4, 3'd6: return lt;
      3'd5, 3'd7: return !lt;
      default:    return 1'b0;
    endcase
  endfunction

  task automatic applyStimulus(input logic v, input logic st, input logic b,
                               input logic j, input logic [2:0] f,
                               input logic lt, input logic eq, input logic p,
                               input logic [XLEN-1:0] pc,
                               input logic [XLEN-1:0] tgt, input logic clr);
    ex_valid = v; ex_stall = st; br_en = b; jmp_en = j; funct3 = f;
    less = lt; equal = eq; pred_taken = p; ex_pc = pc; target_addr = tgt;
    cnt_clr = clr;
  endtask

  // Predict the effect of the upcoming clock edge, then take it.
  task automatic advance();
    logic acc;
    logic act;
    logic mis;
    acc = ex_valid && !ex_stall && (br_en || jmp_en) && (m_blocked == 0);
    act = jmp_en || (br_en && branchCond(funct3, less, equal));
    mis = acc && (act != pred_taken);
    m_redirect = 1'b0;
    m_illegal  = 1'b0;
    if (m_blocked > 0) begin
      m_blocked--;
    end else if (acc) begin
      m_taken   = act;
      m_illegal = br_en && !jmp_en && (funct3 == 3'd2 || funct3 == 3'd3);
      if (mis) begin
        m_redirect = 1'b1;
        m_pc       = act ? target_addr : ex_pc + 32'd4;
        m_blocked  = 1 + SHADOW;
      end
    end
    if (cnt_clr) begin
      m_br = 0;
      m_mp = 0;
    end else begin
      if (acc && m_br < CNT_MAX) m_br++;
      if (mis && m_mp < CNT_MAX) m_mp++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic compareAll(input string tag);
    cmp({tag, ".redirect_valid"}, XLEN'(redirect_valid), XLEN'(m_redirect));
    cmp({tag, ".flush_ifid"},     XLEN'(flush_ifid),     XLEN'(m_redirect));
    cmp({tag, ".flush_idex"},     XLEN'(flush_idex),     XLEN'(m_redirect));
    cmp({tag, ".redirect_pc"},    redirect_pc,           m_pc);
    cmp({tag, ".taken_o"},        XLEN'(taken_o),        XLEN'(m_taken));
    cmp({tag, ".illegal_o"},      XLEN'(illegal_o),      XLEN'(m_illegal));
    cmp({tag, ".br_cnt"},         XLEN'(br_cnt),         XLEN'(m_br));
    cmp({tag, ".mispred_cnt"},    XLEN'(mispred_cnt),    XLEN'(m_mp));
  endtask

  task automatic checkOutput(input string tag);
    advance();
    compareAll(tag);
  endtask

  task automatic idleCycles(input int n);
    applyStimulus(0, 0, 0, 0, 3'd0, 0, 0, 0, '0, '0, 0);
    for (int i = 0; i < n; i++) checkOutput("idle");
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    modelReset();
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 3'd0, 0, 0, 0, '0, '0, 0);
    #12;
    compareAll("reset");
    rst_n = 1'b1;

    // BLT taken, predicted not taken: redirect to target
    applyStimulus(1, 0, 1, 0, 3'd4, 1, 0, 0, 32'h100, 32'h180, 0);
    #1 cmp("blt.br_unsigned", XLEN'(br_unsigned), '0);
    checkOutput("blt");
    cmp("blt.redirect_pc_const", redirect_pc, 32'h180);
    cmp("blt.br_cnt_const", XLEN'(br_cnt), 32'd1);

    // Branches in the two wrong-path cycles are ignored
    applyStimulus(1, 0, 1, 0, 3'd0, 0, 1, 0, 32'h200, 32'h300, 0);
    checkOutput("shadow1");
    checkOutput("shadow2");
    cmp("shadow.br_cnt_const", XLEN'(br_cnt), 32'd1);
    // Back in IDLE: the same (correctly... mispredicted) branch now resolves
    checkOutput("after_shadow");
    idleCycles(2);

    // BGEU correct prediction
    applyStimulus(1, 0, 1, 0, 3'd7, 0, 0, 1, 32'h20, 32'h40, 0);
    #1 cmp("bgeu.br_unsigned", XLEN'(br_unsigned), 32'd1);
    checkOutput("bgeu");
    cmp("bgeu.no_redirect", XLEN'(redirect_valid), '0);

    // BEQ mispredicted taken at top of address space: fall-through wraps
    applyStimulus(1, 0, 1, 0, 3'd0, 0, 0, 1, 32'hFFFF_FFFC, 32'h40, 0);
    checkOutput("beq_wrap");
    cmp("beq_wrap.pc_const", redirect_pc, 32'h0);
    idleCycles(2);

    // Illegal funct3 predicted taken: falls through, one-cycle illegal pulse
    applyStimulus(1, 0, 1, 0, 3'd2, 1, 1, 1, 32'h500, 32'h900, 0);
    checkOutput("illegal");
    cmp("illegal.pulse_const", XLEN'(illegal_o), 32'd1);
    idleCycles(3);

    // Jump wins over branch: no illegal report, redirect to target
    applyStimulus(1, 0, 1, 1, 3'd2, 0, 0, 0, 32'h600, 32'hA00, 0);
    checkOutput("jmp_wins");
    idleCycles(2);

    // Stall blocks resolution until it drops
    applyStimulus(1, 1, 1, 0, 3'd1, 0, 0, 1, 32'h700, 32'h780, 0);
    checkOutput("stall");
    ex_stall = 1'b0;
    checkOutput("unstall");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
                    1'($urandom), ($urandom_range(0, 3) == 0),
                    3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                    {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                    ($urandom_range(0, 40) == 0));
      checkOutput("random");
    end

    // Fill br_cnt to saturation with correctly predicted jumps
    applyStimulus(1, 0, 0, 1, 3'd0, 0, 0, 1, 32'h1000, 32'h2000, 0);
    while (m_br < CNT_MAX) advance();
    compareAll("sat_reach");
    checkOutput("sat_hold1");
    checkOutput("sat_hold2");
    cmp("sat.br_cnt_const", XLEN'(br_cnt), 32'hFFFF);

    // Clear wins over a concurrent accept
    cnt_clr = 1'b1;
    checkOutput("clr_vs_acc");
    cmp("clr.br_cnt_const", XLEN'(br_cnt), 32'h0);
    cnt_clr = 1'b0;

    // Asynchronous reset while the redirect pulse is up
    applyStimulus(1, 0, 1, 0, 3'd0, 0, 1, 0, 32'h3000, 32'h3400, 0);
    checkOutput("pre_reset_redirect");
    #1 rst_n = 1'b0;
    modelReset();
    #1 compareAll("async_reset");
    @(posedge clk);
    #3 rst_n = 1'b1;
    applyStimulus(1, 0, 1, 0, 3'd5, 0, 0, 1, 32'h3100, 32'h3200, 0);
    checkOutput("resume");
    cmp("resume.br_cnt_const", XLEN'(br_cnt), 32'd1);
    idleCycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
